sd_read_scheduler: RTL and testbench

- Shares one SD SPI command/data engine between NUM_REQ block-read requesters, e.g. a CPU port and a loader/DMA port.
- Grants requesters round-robin and issues CMD17 (read single block) with the correct address form for SDSC or SDHC/SDXC.
- Supervises the R1 response and the 512-byte data phase, routes the bytes to the granted requester, and reports per-request completion status.
- Sits between the requesters and the low-level SPI engine, which owns the sd_cclk/sd_cmd/sd_data0 pins.

---
 rtl/sd_read_scheduler.sv | 157 +++++++++++++++
 tb/tb_sd_read_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_scheduler.sv
// Round-robin CMD17 scheduler sharing one SD SPI engine between NUM_REQ block-read requesters.
// Grants, issues the command, supervises R1 and the 512-byte data phase, and reports completion.
module sd_read_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int ID_W           = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_done,
   input  logic                    sdsc,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_lba,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    eng_cmd_valid,
   input  logic                    eng_cmd_ready,
   output logic [5:0]              eng_cmd_index,
   output logic [31:0]             eng_cmd_arg,
   input  logic                    eng_resp_valid,
   input  logic [7:0]              eng_resp_r1,
   input  logic                    eng_data_valid,
   input  logic [7:0]              eng_data,
   input  logic                    eng_data_err,
   output logic                    rd_valid,
   output logic [7:0]              rd_data,
   output logic                    rd_last,
   output logic [ID_W-1:0]         rd_id,
   output logic                    done_valid,
   output logic [ID_W-1:0]         done_id,
   output logic [1:0]              done_status,
   output logic                    busy
);

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_SEND, S_WAIT_R1, S_DATA, S_FINISH} state_t;

   localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);
   localparam logic [20:0] TO_MAX  = '1;
   localparam logic [1:0]  ST_OK = 2'b00, ST_R1 = 2'b01, ST_DATA = 2'b10, ST_TO = 2'b11;

   state_t                    state;
   logic [ID_W-1:0]           rr_ptr, gnt_id, pick, idx, ptr_next;
   logic                      found;
   logic [9:0]                byte_cnt;
   logic [20:0]               to_cnt, to_inc;
   logic [NUM_REQ-1:0][31:0]  lba_arr;

   assign lba_arr = req_lba;
   assign busy    = (state != S_IDLE);
   assign to_inc  = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 21'd1;

   // First pending requester at or above the pointer, wrapping around.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      ptr_next = (int'(pick) == NUM_REQ - 1) ? '0 : ID_W'(int'(pick) + 1);
   end

   // The accept pulse must coincide with the arbitration cycle, so it is decoded from state.
   always_comb begin
      req_ready = '0;
      if (state == S_ARB && found) req_ready[pick] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         gnt_id        <= '0;
         byte_cnt      <= '0;
         to_cnt        <= '0;
         eng_cmd_valid <= 1'b0;
         eng_cmd_index <= '0;
         eng_cmd_arg   <= '0;
         rd_valid      <= 1'b0;
         rd_data       <= '0;
         rd_last       <= 1'b0;
         rd_id         <= '0;
         done_valid    <= 1'b0;
         done_id       <= '0;
         done_status   <= '0;
      end else begin
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         done_valid <= 1'b0;
         case (state)
            S_IDLE: if (init_done && |req_valid) state <= S_ARB;
            S_ARB: begin
               if (found) begin
                  gnt_id        <= pick;
                  rr_ptr        <= ptr_next;
                  eng_cmd_arg   <= sdsc ? {lba_arr[pick][22:0], 9'b0} : lba_arr[pick];
                  eng_cmd_index <= 6'd17;
                  eng_cmd_valid <= 1'b1;
                  byte_cnt      <= '0;
                  state         <= S_SEND;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SEND: if (eng_cmd_ready) begin
               eng_cmd_valid <= 1'b0;
               to_cnt        <= '0;
               state         <= S_WAIT_R1;
            end
            S_WAIT_R1: begin
               if (eng_resp_valid) begin
                  to_cnt <= '0;
                  if (eng_resp_r1 == 8'h00) begin
                     state <= S_DATA;
                  end else begin
                     done_valid <= 1'b1; done_id <= gnt_id; done_status <= ST_R1;
                     state      <= S_FINISH;
                  end
               end else if (to_cnt == TO_LAST) begin
                  done_valid <= 1'b1; done_id <= gnt_id; done_status <= ST_TO;
                  state      <= S_FINISH;
               end else begin
                  to_cnt <= to_inc;
               end
            end
            S_DATA: begin
               if (eng_data_err) begin
                  done_valid <= 1'b1; done_id <= gnt_id; done_status <= ST_DATA;
                  state      <= S_FINISH;
               end else if (eng_data_valid) begin
                  rd_valid <= 1'b1;
                  rd_data  <= eng_data;
                  rd_id    <= gnt_id;
                  byte_cnt <= byte_cnt + 10'd1;
                  to_cnt   <= '0;
                  if (byte_cnt == 10'd511) begin
                     rd_last    <= 1'b1;
                     done_valid <= 1'b1; done_id <= gnt_id; done_status <= ST_OK;
                     state      <= S_FINISH;
                  end
               end else if (to_cnt == TO_LAST) begin
                  done_valid <= 1'b1; done_id <= gnt_id; done_status <= ST_TO;
                  state      <= S_FINISH;
               end else begin
                  to_cnt <= to_inc;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_read_scheduler.sv
// Randomized scoreboard bench for sd_read_scheduler: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_sd_read_scheduler;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;
   localparam int T       = 100;
   localparam int K_OK = 0, K_R1ERR = 1, K_NORESP = 2, K_DERR = 3, K_GAP = 4, K_RST = 5;

   logic                  clk, rst, init_done, sdsc;
   logic [NUM_REQ-1:0]    req_valid, req_ready;
   logic [NUM_REQ*32-1:0] req_lba;
   logic                  eng_cmd_valid, eng_cmd_ready;
   logic [5:0]            eng_cmd_index;
   logic [31:0]           eng_cmd_arg;
   logic                  eng_resp_valid, eng_data_valid, eng_data_err;
   logic [7:0]            eng_resp_r1, eng_data;
   logic                  rd_valid, rd_last, done_valid, busy;
   logic [7:0]            rd_data;
   logic [ID_W-1:0]       rd_id, done_id;
   logic [1:0]            done_status;

   sd_read_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(T), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .sdsc(sdsc),
      .req_valid(req_valid), .req_lba(req_lba), .req_ready(req_ready),
      .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
      .eng_cmd_index(eng_cmd_index), .eng_cmd_arg(eng_cmd_arg),
      .eng_resp_valid(eng_resp_valid), .eng_resp_r1(eng_resp_r1),
      .eng_data_valid(eng_data_valid), .eng_data(eng_data), .eng_data_err(eng_data_err),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_id(rd_id),
      .done_valid(done_valid), .done_id(done_id), .done_status(done_status), .busy(busy)
   );

   typedef struct packed { logic [7:0] data; logic last; logic [ID_W-1:0] id; } rd_exp_t;
   typedef struct { int id; int status; int cyc; } done_exp_t;

   int          exp_grant_q[$];
   logic [31:0] exp_arg_q[$];
   rd_exp_t     exp_rd_q[$];
   done_exp_t   exp_done_q[$];

   int checks = 0, errors = 0, grant_cnt = 0, done_cnt = 0, cyc = 0, m_ptr = 0;
   bit mon_en = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s unexpected output actual=%0h (cycle %0d)", name, act, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = wait for a grant, 1 = wait for a completion
   task automatic wait_evt(input int which, input int budget, output bit ok);
      int start;
      start = which ? done_cnt : grant_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if ((which ? done_cnt : grant_cnt) != start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL wait_%s no event within %0d cycles", which ? "done" : "grant", budget);
      end
   endtask

   // Monitor: every DUT output event is matched against the head of its expectation queue.
   always @(negedge clk) begin
      int        mg;
      logic [31:0] ma;
      rd_exp_t   mr;
      done_exp_t md;
      if (mon_en) begin
         if (req_ready != '0) begin
            if (exp_grant_q.size() == 0) unexp("grant", 64'(req_ready));
            else begin
               mg = exp_grant_q.pop_front();
               chk("grant", 64'(req_ready), 64'(1) << mg);
            end
            grant_cnt++;
         end
         if (eng_cmd_valid && eng_cmd_ready) begin
            if (exp_arg_q.size() == 0) unexp("cmd", 64'(eng_cmd_arg));
            else begin
               ma = exp_arg_q.pop_front();
               chk("cmd_arg", 64'(eng_cmd_arg), 64'(ma));
               chk("cmd_index", 64'(eng_cmd_index), 64'd17);
            end
         end
         if (rd_valid) begin
            if (exp_rd_q.size() == 0) unexp("rd", 64'(rd_data));
            else begin
               mr = exp_rd_q.pop_front();
               chk("rd_data", 64'(rd_data), 64'(mr.data));
               chk("rd_last", 64'(rd_last), 64'(mr.last));
               chk("rd_id", 64'(rd_id), 64'(mr.id));
            end
         end
         if (done_valid) begin
            if (exp_done_q.size() == 0) unexp("done", 64'(done_status));
            else begin
               md = exp_done_q.pop_front();
               chk("done_id", 64'(done_id), 64'(md.id));
               chk("done_status", 64'(done_status), 64'(md.status));
               if (md.cyc >= 0) chk("done_time", 64'(cyc), 64'(md.cyc));
            end
            done_cnt++;
         end
      end
   end

   task automatic push_done(input int id, input int st, input int c);
      done_exp_t de;
      de.id = id; de.status = st; de.cyc = c;
      exp_done_q.push_back(de);
   endtask

   // One request/engine transaction; called at posedge+1 while the DUT idles.
   task automatic run_txn(input logic [1:0] vmask, input bit hold, input bit s, input int kind,
                          input int stop_at, input bit pattern, input logic [31:0] l0, input logic [31:0] l1);
      int g, hs, lst, n, cand;
      bit ok;
      logic [31:0] lba;
      logic [7:0] b;
      rd_exp_t re;
      sdsc = s; req_lba = {l1, l0}; req_valid = vmask;
      // Reference: first requesting port from the pointer upward with wrap; argument = lba*512 for SDSC.
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (m_ptr + k) % NUM_REQ;
         if (g < 0 && ((vmask >> cand) & 2'b01) != 2'b00) g = cand;
      end
      m_ptr = (g + 1) % NUM_REQ;
      lba = (g == 1) ? l1 : l0;
      exp_grant_q.push_back(g);
      exp_arg_q.push_back(s ? lba * 32'd512 : lba);
      wait_evt(0, 20, ok);
      if (!ok) return;
      req_valid = hold ? vmask : 2'b00;

      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (eng_cmd_valid) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL cmd_valid never asserted");
         return;
      end
      repeat ($urandom_range(0, 3)) tick();
      eng_cmd_ready = 1'b1;
      tick();
      hs = cyc;
      eng_cmd_ready = 1'b0;

      if (kind == K_NORESP) begin
         push_done(g, 3, hs + T);
         wait_evt(1, T + 20, ok);
         return;
      end
      repeat ($urandom_range(0, 5)) tick();
      eng_resp_valid = 1'b1;
      eng_resp_r1 = (kind == K_R1ERR) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (kind == K_R1ERR) push_done(g, 1, -1);
      tick();
      lst = cyc;
      eng_resp_valid = 1'b0;
      eng_resp_r1 = 8'($urandom);
      if (kind == K_R1ERR) begin
         wait_evt(1, 20, ok);
         return;
      end

      n = (kind == K_OK) ? 512 : stop_at;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         b = pattern ? 8'(i) : 8'($urandom);
         re.data = b; re.last = (i == 511); re.id = ID_W'(g);
         exp_rd_q.push_back(re);
         if (i == 511) push_done(g, 0, -1);
         eng_data_valid = 1'b1; eng_data = b;
         tick();
         lst = cyc;
         eng_data_valid = 1'b0; eng_data = 8'($urandom);
      end

      case (kind)
         K_OK: wait_evt(1, 20, ok);
         K_DERR: begin
            push_done(g, 2, -1);
            repeat ($urandom_range(0, 2)) tick();
            eng_data_err = 1'b1;
            eng_data_valid = 1'($urandom_range(0, 1));
            eng_data = 8'($urandom);
            tick();
            eng_data_err = 1'b0; eng_data_valid = 1'b0;
            wait_evt(1, 20, ok);
         end
         K_GAP: begin
            push_done(g, 3, lst + T);
            wait_evt(1, T + 20, ok);
         end
         K_RST: begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            m_ptr = 0;
            @(negedge clk);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rd_valid", 64'(rd_valid), 64'd0);
            chk("rst_done_valid", 64'(done_valid), 64'd0);
            tick();
            eng_resp_valid = 1'b1; eng_resp_r1 = 8'h00;
            tick();
            eng_resp_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
               eng_data_valid = 1'b1; eng_data = 8'($urandom);
               tick();
               eng_data_valid = 1'b0;
               tick();
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      int kind;
      rst = 1'b1; init_done = 1'b0; sdsc = 1'b0; req_valid = '0; req_lba = '0;
      eng_cmd_ready = 1'b0; eng_resp_valid = 1'b0; eng_resp_r1 = '0;
      eng_data_valid = 1'b0; eng_data = '0; eng_data_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_cmd_valid", 64'(eng_cmd_valid), 64'd0);
      chk("reset_cmd_index", 64'(eng_cmd_index), 64'd0);
      chk("reset_cmd_arg", 64'(eng_cmd_arg), 64'd0);
      chk("reset_rd", 64'({rd_valid, rd_last, rd_data, rd_id}), 64'd0);
      chk("reset_done", 64'({done_valid, done_id, done_status}), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      init_done = 1'b1;

      run_txn(2'b01, 1'b0, 1'b1, K_OK, 0, 1'b1, 32'd3, $urandom);
      run_txn(2'b10, 1'b0, 1'b0, K_OK, 0, 1'b0, $urandom, 32'h00012345);
      for (int i = 0; i < 4; i++)
         run_txn(2'b11, (i < 3), 1'($urandom_range(0, 1)), K_OK, 0, 1'b0, $urandom, $urandom);
      run_txn(2'($urandom_range(1, 3)), 1'b0, 1'b1, K_R1ERR, 0, 1'b0, $urandom, $urandom);
      run_txn(2'($urandom_range(1, 3)), 1'b0, 1'b0, K_OK, 0, 1'b0, $urandom, $urandom);
      run_txn(2'($urandom_range(1, 3)), 1'b0, 1'b0, K_NORESP, 0, 1'b0, $urandom, $urandom);
      run_txn(2'($urandom_range(1, 3)), 1'b0, 1'b1, K_DERR, $urandom_range(0, 40), 1'b0, $urandom, $urandom);
      run_txn(2'($urandom_range(1, 3)), 1'b0, 1'b0, K_GAP, $urandom_range(1, 5), 1'b0, $urandom, $urandom);
      for (int i = 0; i < 6; i++) begin
         kind = $urandom_range(0, 6);
         if (kind > K_GAP) kind = K_OK;
         run_txn(2'($urandom_range(1, 3)), 1'b0, 1'($urandom_range(0, 1)), kind,
                 $urandom_range(0, 30), 1'b0, $urandom, $urandom);
      end

      run_txn(2'b01, 1'b0, 1'b0, K_RST, 100, 1'b0, $urandom, $urandom);

      init_done = 1'b0; req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("noinit_req_ready", 64'(req_ready), 64'd0);
         chk("noinit_busy", 64'(busy), 64'd0);
      end
      tick();
      req_valid = 2'b00; init_done = 1'b1;
      run_txn(2'b11, 1'b0, 1'b0, K_OK, 0, 1'b0, $urandom, $urandom);

      repeat (5) tick();
      chk("grant_q_drained", 64'(exp_grant_q.size()), 64'd0);
      chk("arg_q_drained", 64'(exp_arg_q.size()), 64'd0);
      chk("rd_q_drained", 64'(exp_rd_q.size()), 64'd0);
      chk("done_q_drained", 64'(exp_done_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
